// File: rtl/mips_mem_pkg.sv
// Shared constants and address helpers for the MIPS memory responder.
package mips_mem_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_SB_DEPTH = 4;

    // Byte address to word index; callers truncate to their array width, which wraps.
    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/mips_store_buffer.sv
// Posted-store FIFO with sticky overflow flag and two youngest-match lookup ports.
module mips_store_buffer
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_SB_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_idx,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_idx,
    output logic [WORD_W-1:0] head_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              err,
    input  logic [ADDR_W-1:0] fetch_idx,
    output logic              fetch_hit,
    output logic [WORD_W-1:0] fetch_data,
    input  logic [ADDR_W-1:0] data_idx,
    output logic              data_hit,
    output logic [WORD_W-1:0] data_data
);

    logic [ADDR_W-1:0] idx_q  [DEPTH];
    logic [WORD_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;
    logic              full, do_pop, accept;
    logic [PTR_W-1:0]  ptr;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CNT_W'(DEPTH));
    assign do_pop = rst && pop && !empty;
    // A full buffer still accepts when the head leaves on the same edge.
    assign accept = rst && push && (!full || do_pop);

    assign head_idx  = idx_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) tail_q <= tail_q + PTR_W'(1);
            if (do_pop) head_q <= head_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(accept) - CNT_W'(do_pop);
            if (push && !accept) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q[tail_q]  <= push_idx;
            data_q[tail_q] <= push_data;
        end
    end

    // Walk oldest to youngest so the last hit wins.
    always_comb begin
        fetch_hit  = 1'b0;
        fetch_data = '0;
        data_hit   = 1'b0;
        data_data  = '0;
        ptr        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ptr = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (idx_q[ptr] == fetch_idx) begin
                    fetch_hit  = 1'b1;
                    fetch_data = data_q[ptr];
                end
                if (idx_q[ptr] == data_idx) begin
                    data_hit  = 1'b1;
                    data_data = data_q[ptr];
                end
            end
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Word array serving MIPS fetch and data ports, with posted stores and a host loader.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               PC,
    output logic [31:0]               Instruction,
    input  logic [31:0]               Address,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [31:0]               Write_data,
    output logic [31:0]               Read_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [31:0]               ld_data,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_err
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] fetch_idx, data_idx, head_idx, waddr;
    logic [WORD_W-1:0] head_data, wdata, fetch_fwd, data_fwd;
    logic              fetch_hit, data_hit, sb_empty, sb_pop, mem_we;

    assign fetch_idx = ADDR_W'(word_index(PC));
    assign data_idx  = ADDR_W'(word_index(Address));

    // Loader has priority; the buffer drains only on loader-idle cycles.
    assign ld_ready = rst & ld_valid;
    assign sb_pop   = rst & ~ld_valid & ~sb_empty;
    assign mem_we   = ld_ready | sb_pop;

    always_comb begin
        waddr = head_idx;
        wdata = head_data;
        if (ld_ready) begin
            waddr = ld_addr;
            wdata = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr] <= wdata;
    end

    mips_store_buffer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (SB_DEPTH)
    ) u_store_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (MemWrite),
        .push_idx   (data_idx),
        .push_data  (Write_data),
        .pop        (sb_pop),
        .head_idx   (head_idx),
        .head_data  (head_data),
        .empty      (sb_empty),
        .count      (sb_count),
        .err        (sb_err),
        .fetch_idx  (fetch_idx),
        .fetch_hit  (fetch_hit),
        .fetch_data (fetch_fwd),
        .data_idx   (data_idx),
        .data_hit   (data_hit),
        .data_data  (data_fwd)
    );

    assign Instruction = fetch_hit ? fetch_fwd : mem[fetch_idx];
    assign Read_data   = !MemRead ? '0 : (data_hit ? data_fwd : mem[data_idx]);

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the multi-cycle MIPS core: serves the core's instruction-fetch port (PC/Instruction) and data port (Address/MemRead/MemWrite/Write_data/Read_data) from one word-addressed array. Core stores are posted into a small store buffer and drained into the array. A host loader port shares the array write port for program/data preload. Reads are combinational, because the core samples Instruction and Read_data at the end of the same cycle that presents the address.

## Interface
- `ADDR_W`, default 10: word-address width; array holds 2^ADDR_W 32-bit words.
- `SB_DEPTH`, default 4: store-buffer entries; power of two, at least 2.
- `clk`, input, 1: the only clock.
- `rst`, input, 1: synchronous, active-low reset.
- `PC`, input, 32: fetch byte address.
- `Instruction`, output, 32: fetched word, combinational.
- `Address`, input, 32: data byte address.
- `MemRead`, input, 1: data read enable.
- `MemWrite`, input, 1: data store strobe; one store per high cycle.
- `Write_data`, input, 32: store data.
- `Read_data`, output, 32: load data, combinational; 0 when MemRead=0.
- `ld_valid`, input, 1: loader write request.
- `ld_ready`, output, 1: loader write accepted this cycle.
- `ld_addr`, input, ADDR_W: loader word address.
- `ld_data`, input, 32: loader write data.
- `sb_count`, output, $clog2(SB_DEPTH)+1: current store-buffer occupancy.
- `sb_err`, output, 1: sticky flag; a store was dropped on overflow.

## Operation
- Word index is byte address bits [ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so out-of-range addresses wrap.
- Store buffer is a FIFO of {word index, data}.
  - When MemWrite=1, the store is enqueued at the clock edge.
  - If the buffer is full and no drain occurs that cycle, the store is dropped and sb_err is set to 1.
  - If the buffer is full and a drain occurs in the same cycle, the store is accepted; no error.
- Array write-port arbitration, once per cycle:
  - If ld_valid=1, the loader wins: ld_ready=1 and array[ld_addr] is written with ld_data.
  - Otherwise, if the buffer is non-empty, the oldest entry is popped and written to the array.
  - ld_ready is combinational: equal to ld_valid while rst=1, and 0 during reset.
- Read path, identical for fetch and data:
  - If the word index matches any buffer entry, the youngest matching entry's data is returned.
  - Otherwise the array word is returned.
  - Entries being popped in the current cycle still count as present until the edge.
  - Read-during-store in the same cycle returns the pre-store value. The core never does this.
- Loader writes and buffered stores to the same index: the buffered data is what reads see until it drains. The drain then overwrites the loader value; stores are younger by definition.

## Timing
- Reads: zero-cycle combinational from PC/Address to Instruction/Read_data.
- Store: visible to reads (via forwarding) from the cycle after MemWrite. It reaches the array at least 1 cycle later, delayed further for each cycle ld_valid=1.
- Enqueue, pop, and sb_count update on the same edge; sb_count reflects post-edge occupancy.
- Reset (rst=0 at an edge):
  - Buffer emptied, sb_count=0, sb_err=0; pending stores are discarded.
  - Array contents are retained.
  - ld_ready=0 and MemWrite is ignored while rst=0.
- sb_err clears only on reset.

## Structure
- Package `mips_mem_pkg` holds:
  - WORD_W=32.
  - The byte-to-word index function/macro.
  - Default ADDR_W and SB_DEPTH.
- Sub-module `mips_store_buffer`:
  - Circular FIFO with head/tail pointers and count.
  - Parallel CAM-style youngest-match lookup with two lookup ports (fetch and data).
- Top level holds the array, the write arbiter, and the read muxes.

## Test plan
- Loader preload: write array[0..3] = 0x11,0x22,0x33,0x44 with ld_valid held 4 cycles -> ld_ready=1 each cycle; PC=0x8 -> Instruction=0x33.
- Store forwarding: MemWrite, Address=0x10, Write_data=0xDEADBEEF -> next cycle, MemRead with Address=0x10 gives Read_data=0xDEADBEEF and sb_count=1. Following cycle: sb_count=0 and the array holds the value.
- Youngest match: with ld_valid held high, store 0xA then 0xB to 0x20 -> Read_data=0xB and sb_count=2. Release ld_valid -> drains in 2 cycles; final array[8]=0xB.
- Overflow: ld_valid held high, 5 stores with SB_DEPTH=4 -> sb_count=4, sb_err=1, 5th store absent from reads. Same test with ld_valid low on the 5th cycle -> sb_err stays 0.
- Wrap/alignment: Address=0x1003 with ADDR_W=10 -> reads word 0; PC=0x2 -> word 0.
- Reset mid-operation: 2 stores buffered, then rst=0 for one cycle -> sb_count=0, sb_err=0, buffered data not visible, earlier array contents preserved.
